// File: rtl/db_target.sv
// db_target: SRIO target-side endpoint. Answers self-check and
// data-integration doorbells with a response doorbell on ireq, and unpacks
// NWRITE payload beats onto a local byte-addressed write port.
module db_target #(
    parameter int ADDR_W = 34
) (
    input  logic              log_clk,
    input  logic              log_rst,
    input  logic [7:0]        src_id,
    input  logic              local_busy_in,
    input  logic              treq_tvalid_in,
    output logic              treq_tready_o,
    input  logic              treq_tlast_in,
    input  logic [63:0]       treq_tdata_in,
    input  logic [7:0]        treq_tkeep_in,
    input  logic [31:0]       treq_tuser_in,
    output logic              ireq_tvalid_o,
    input  logic              ireq_tready_in,
    output logic              ireq_tlast_o,
    output logic [63:0]       ireq_tdata_o,
    output logic [7:0]        ireq_tkeep_o,
    output logic [31:0]       ireq_tuser_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [63:0]       wr_data_o,
    output logic [7:0]        wr_keep_o,
    output logic [19:0]       rx_bytes_o,
    output logic              data_done_o,
    output logic              len_err_o,
    output logic              drop_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NWR_DATA,
        S_DB_SEND,
        S_DROP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [5:0]          r_exp;
    logic [5:0]          r_beats;
    logic [15:0]         r_reply;
    logic [7:0]          r_req_src;
    logic                r_is_int;
    logic [19:0]         r_rx_bytes;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [63:0]         r_wr_data;
    logic [7:0]          r_wr_keep;
    logic                r_done;
    logic                r_len_err;
    logic                r_drop;

    // Header decode of the current treq beat
    logic                w_treq_hs;
    logic [3:0]          w_ftype;
    logic [3:0]          w_ttype;
    logic [7:0]          w_size;
    logic [15:0]         w_info;
    logic                w_is_db;
    logic                w_is_nwr;
    logic                w_info_self;
    logic                w_info_int;
    logic                w_rx_nz;
    logic [15:0]         w_reply;

    // FSM strobes into the datapath
    logic                w_db_load;
    logic                w_nwr_start;
    logic                w_nwr_beat;
    logic                w_drop_nxt;
    logic                w_len_err_nxt;
    logic                w_int_done;

    logic [5:0]          w_beats_inc;
    logic [3:0]          w_keep_cnt;
    logic [20:0]         w_rx_sum;
    logic [19:0]         w_rx_sat;
    logic                w_unused_tuser;

    assign w_treq_hs   = treq_tvalid_in & treq_tready_o;
    assign w_ftype     = treq_tdata_in[55:52];
    assign w_ttype     = treq_tdata_in[51:48];
    assign w_size      = treq_tdata_in[43:36];
    assign w_info      = treq_tdata_in[31:16];
    assign w_is_db     = (w_ftype == 4'hA) & treq_tlast_in;
    assign w_is_nwr    = (w_ftype == 4'h5) & (w_ttype == 4'h4) & ~treq_tlast_in;
    assign w_info_self = (w_info == 16'h0101);
    assign w_info_int  = (w_info == 16'h0200) | (w_info == 16'h0201);
    assign w_rx_nz     = (r_rx_bytes != 20'h0);

    // Only the requester's low source byte is echoed back for routing
    assign w_unused_tuser = ^{treq_tuser_in[31:24], treq_tuser_in[15:0]};

    // Reply code chosen at header time; busy is sampled in the handshake cycle
    assign w_reply = w_info_self ? (local_busy_in ? 16'h01FF : 16'h0100)
                                 : (w_rx_nz ? w_info : 16'h02FF);

    // Beat counter saturates so an overlong packet can never alias to a match
    assign w_beats_inc = (r_beats == 6'h3F) ? r_beats : r_beats + 6'd1;

    // Byte count of the current beat from its keep mask
    always_comb begin
        w_keep_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_keep_cnt = w_keep_cnt + {3'b000, treq_tkeep_in[i]};
        end
    end

    assign w_rx_sum = {1'b0, r_rx_bytes} + {17'b0, w_keep_cnt};
    assign w_rx_sat = w_rx_sum[20] ? 20'hFFFFF : w_rx_sum[19:0];

    // State register
    always_ff @(posedge log_clk) begin
        if (log_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode, datapath strobes and ireq/treq handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_db_load     = 1'b0;
        w_nwr_start   = 1'b0;
        w_nwr_beat    = 1'b0;
        w_drop_nxt    = 1'b0;
        w_len_err_nxt = 1'b0;
        w_int_done    = 1'b0;
        treq_tready_o = 1'b1;
        ireq_tvalid_o = 1'b0;
        ireq_tlast_o  = 1'b0;
        ireq_tdata_o  = 64'h0;
        ireq_tkeep_o  = 8'h00;
        ireq_tuser_o  = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_treq_hs) begin
                    if (w_is_db) begin
                        if (w_info_self | w_info_int) begin
                            w_db_load   = 1'b1;
                            w_state_nxt = S_DB_SEND;
                        end else begin
                            w_drop_nxt  = 1'b1;
                        end
                    end else if (w_is_nwr) begin
                        w_nwr_start = 1'b1;
                        w_state_nxt = S_NWR_DATA;
                    end else begin
                        w_drop_nxt = 1'b1;
                        if (!treq_tlast_in) w_state_nxt = S_DROP;
                    end
                end
            end
            S_NWR_DATA: begin
                if (w_treq_hs) begin
                    w_nwr_beat = 1'b1;
                    if (treq_tlast_in) begin
                        w_state_nxt   = S_IDLE;
                        w_len_err_nxt = (w_beats_inc != r_exp);
                    end
                end
            end
            S_DB_SEND: begin
                treq_tready_o = 1'b0;
                ireq_tvalid_o = 1'b1;
                ireq_tlast_o  = 1'b1;
                ireq_tkeep_o  = 8'hFF;
                ireq_tdata_o  = {8'h00, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h0,
                                 r_reply, 16'h0};
                ireq_tuser_o  = {8'h0, src_id, 8'h0, r_req_src};
                if (ireq_tready_in) begin
                    w_state_nxt = S_IDLE;
                    w_int_done  = r_is_int;
                end
            end
            S_DROP: begin
                if (w_treq_hs && treq_tlast_in) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: reply latch, NWRITE address/beat tracking, write port, pulses
    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            r_addr     <= '0;
            r_exp      <= 6'd0;
            r_beats    <= 6'd0;
            r_reply    <= 16'h0;
            r_req_src  <= 8'h0;
            r_is_int   <= 1'b0;
            r_rx_bytes <= 20'h0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 64'h0;
            r_wr_keep  <= 8'h00;
            r_done     <= 1'b0;
            r_len_err  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_wr_en   <= w_nwr_beat;
            r_drop    <= w_drop_nxt;
            r_len_err <= w_len_err_nxt;
            r_done    <= w_int_done;
            if (w_db_load) begin
                r_reply   <= w_reply;
                r_req_src <= treq_tuser_in[23:16];
                r_is_int  <= w_info_int & w_rx_nz;
            end
            if (w_nwr_start) begin
                r_addr  <= treq_tdata_in[ADDR_W-1:0];
                r_exp   <= {1'b0, w_size[7:3]} + 6'd1;
                r_beats <= 6'd0;
            end
            if (w_nwr_beat) begin
                r_wr_addr <= r_addr;
                r_wr_data <= treq_tdata_in;
                r_wr_keep <= treq_tkeep_in;
                r_addr    <= r_addr + ADDR_W'(8);
                r_beats   <= w_beats_inc;
            end
            // Integration ack and payload beats are never in the same cycle
            if (w_int_done)      r_rx_bytes <= 20'h0;
            else if (w_nwr_beat) r_rx_bytes <= w_rx_sat;
        end
    end

    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign wr_keep_o   = r_wr_keep;
    assign rx_bytes_o  = r_rx_bytes;
    assign data_done_o = r_done;
    assign len_err_o   = r_len_err;
    assign drop_o      = r_drop;

endmodule
